mul_sequencer: RTL

Multi-cycle unsigned 32×32→64 multiply controller that sequences the shared datapath ALU through shift-and-add iterations, one ALU ADD per clock. It sits beside the ALU in the data path. While busy it owns the ALU's A/B/operation/carry-in inputs through the datapath mux, and it returns the 64-bit product to the register-file write-back path with a start/busy/done handshake.

---
 rtl/mul_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// Sequential 32x32->64 unsigned shift-and-add multiplier that drives the shared datapath ALU.
// Optional build macro MUL_EARLY_EXIT_EN finishes early once the remaining multiplier bits are zero.
module mul_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [4:0]  ALU_ADD = 5'b00100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             hi_nonzero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] prod_hi_q;
    logic [WIDTH-1:0] prod_lo_q;
    logic             hi_nz_q;
    logic [2*WIDTH-1:0] pq_step_d;

    // One iteration: the 65-bit {carry, sum, Q} shifted right by one.
    always_comb begin
        pq_step_d = {alu_c, alu_result, q_q[WIDTH-1:1]};
    end

`ifdef MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]   r_q;
    logic [2*WIDTH-1:0] pq_skip_d;

    // No multiplier bits left: the remaining iterations would only shift.
    always_comb begin
        pq_skip_d = {p_q, q_q} >> ((CW+1)'(WIDTH) - {1'b0, count_q});
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
            hi_nz_q   <= 1'b0;
`ifdef MUL_EARLY_EXIT_EN
            r_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= op_a;
                        p_q     <= '0;
                        q_q     <= op_b;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef MUL_EARLY_EXIT_EN
                        r_q     <= op_b;
`endif
                    end
                end
                RUN: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (r_q == '0) begin
                        {p_q, q_q} <= pq_skip_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        {p_q, q_q} <= pq_step_d;
                        r_q        <= r_q >> 1;
                        count_q    <= count_q + 1'b1;
                        if (count_q == '1) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
`else
                    {p_q, q_q} <= pq_step_d;
                    count_q    <= count_q + 1'b1;
                    if (count_q == '1) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
`endif
                end
                DONE: begin
                    prod_hi_q <= p_q;
                    prod_lo_q <= q_q;
                    hi_nz_q   <= |p_q;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = prod_hi_q;
    assign product_lo = prod_lo_q;
    assign hi_nonzero = hi_nz_q;
    assign alu_a      = p_q;
    assign alu_b      = (state_q == RUN && q_q[0]) ? m_q : '0;
    assign alu_op     = ALU_ADD;
    assign alu_cin    = 1'b0;

endmodule
